// File: rtl/clock_ratio_meter_pkg.sv
// Shared types and constants for the clock ratio meter and its synchroniser.
// Imported by the top and the edge-detector sub-module.
package clock_ratio_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } meter_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int MATCH_WIDTH = 4;

endpackage

// File: rtl/sync_edge_detector.sv
// Multi-flop synchroniser for an asynchronous level, plus a history flop that
// turns the synchronised level into single-cycle rise and fall strobes.
module sync_edge_detector
    import clock_ratio_meter_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              hist_r;

    // Shift the asynchronous input through the synchroniser, keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_in};
            hist_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~hist_r;
    assign fall  = ~sync_r[STAGES-1] & hist_r;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period and high time of a slow clock in input_clock cycles,
// reports lock after repeated identical captures and flags a stalled clock.
module clock_ratio_meter
    import clock_ratio_meter_pkg::*;
#(
    parameter int COUNTER_WIDTH  = 16,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     input_clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     measured_clock,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic [COUNTER_WIDTH-1:0] high_time,
    output logic                     period_valid,
    output logic                     locked,
    output logic                     timeout
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE     = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_VAL = COUNTER_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [MATCH_WIDTH-1:0]   MATCH_ONE   = MATCH_WIDTH'(1);
    localparam logic [MATCH_WIDTH-1:0]   LOCK_VAL    = MATCH_WIDTH'(LOCK_COUNT);

    meter_state_t               state_r;
    logic [COUNTER_WIDTH-1:0]   period_cnt_r;
    logic [COUNTER_WIDTH-1:0]   high_cnt_r;
    logic [MATCH_WIDTH-1:0]     match_cnt_r;

    logic                       level_s;
    logic                       rise_s;
    logic                       fall_s;
    logic                       capture_s;
    logic                       timeout_hit_s;
    logic                       pair_equal_s;
    logic [MATCH_WIDTH-1:0]     next_match_s;
    logic [COUNTER_WIDTH-1:0]   period_cnt_next_s;
    logic [COUNTER_WIDTH-1:0]   high_cnt_next_s;

    sync_edge_detector #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (input_clock),
        .rst_n    (reset_n),
        .async_in (measured_clock),
        .level    (level_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // Saturating counter updates, capture/timeout qualifiers and next match count
    always_comb begin
        capture_s         = 1'b0;
        timeout_hit_s     = 1'b0;
        pair_equal_s      = 1'b0;
        next_match_s      = MATCH_ONE;
        period_cnt_next_s = period_cnt_r;
        high_cnt_next_s   = high_cnt_r;

        case (state_r)
            ST_MEASURE, ST_LOCKED: capture_s = rise_s;
            default:               capture_s = 1'b0;
        endcase

        // A rise coinciding with the limit wins over the timeout
        if ((state_r != ST_IDLE) && (period_cnt_r == TIMEOUT_VAL) && !rise_s) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end

        pair_equal_s = (period_cnt_r == period) && (high_cnt_r == high_time);

        if (match_cnt_r == '0) begin
            next_match_s = MATCH_ONE;
        end else if (!pair_equal_s) begin
            next_match_s = MATCH_ONE;
        end else if (match_cnt_r >= LOCK_VAL) begin
            next_match_s = LOCK_VAL;
        end else begin
            next_match_s = match_cnt_r + MATCH_ONE;
        end

        if (rise_s) begin
            period_cnt_next_s = CNT_ONE;
        end else if (period_cnt_r == CNT_MAX) begin
            period_cnt_next_s = period_cnt_r;
        end else begin
            period_cnt_next_s = period_cnt_r + CNT_ONE;
        end

        // The rise cycle itself is the first high cycle; a fall ends the high phase
        if (rise_s) begin
            high_cnt_next_s = CNT_ONE;
        end else if (fall_s) begin
            high_cnt_next_s = high_cnt_r;
        end else if (level_s && (high_cnt_r != CNT_MAX)) begin
            high_cnt_next_s = high_cnt_r + CNT_ONE;
        end else begin
            high_cnt_next_s = high_cnt_r;
        end
    end

    // Measurement state machine with registered outputs
    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            period_cnt_r <= '0;
            high_cnt_r   <= '0;
            match_cnt_r  <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else if (!enable) begin
            state_r      <= ST_IDLE;
            period_cnt_r <= '0;
            high_cnt_r   <= '0;
            match_cnt_r  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r      <= ST_ARM;
                    period_cnt_r <= '0;
                    high_cnt_r   <= '0;
                end
                ST_ARM, ST_MEASURE, ST_LOCKED: begin
                    if (rise_s) begin
                        period_cnt_r <= period_cnt_next_s;
                        high_cnt_r   <= high_cnt_next_s;
                        if (capture_s) begin
                            period       <= period_cnt_r;
                            high_time    <= high_cnt_r;
                            period_valid <= 1'b1;
                            timeout      <= 1'b0;
                            match_cnt_r  <= next_match_s;
                            locked       <= (next_match_s == LOCK_VAL);
                            state_r      <= (next_match_s == LOCK_VAL) ? ST_LOCKED : ST_MEASURE;
                        end else begin
                            state_r <= ST_MEASURE;
                        end
                    end else if (timeout_hit_s) begin
                        timeout      <= 1'b1;
                        locked       <= 1'b0;
                        match_cnt_r  <= '0;
                        period       <= '0;
                        high_time    <= '0;
                        period_cnt_r <= '0;
                        high_cnt_r   <= '0;
                        state_r      <= ST_ARM;
                    end else begin
                        period_cnt_r <= period_cnt_next_s;
                        high_cnt_r   <= high_cnt_next_s;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    period_cnt_r <= '0;
                    high_cnt_r   <= '0;
                    match_cnt_r  <= '0;
                    locked       <= 1'b0;
                    timeout      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter: a table of waveform segments with
// hand-computed captures, plus sequences for latency, timeout, disable and reset.
module tb_clock_ratio_meter;

    logic        input_clock;
    logic        reset_n;
    logic        enable;
    logic        measured_clock;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        period_valid;
    logic        locked;
    logic        timeout;

    int checks;
    int errors;
    int pv_count;

    typedef struct {
        int   h;
        int   l;
        int   n;
        int   exp_caps;
        int   exp_period;
        int   exp_high;
        logic exp_locked;
    } vec_t;

    vec_t vecs[9];

    clock_ratio_meter #(
        .COUNTER_WIDTH  (16),
        .LOCK_COUNT     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .input_clock    (input_clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .measured_clock (measured_clock),
        .period         (period),
        .high_time      (high_time),
        .period_valid   (period_valid),
        .locked         (locked),
        .timeout        (timeout)
    );

    initial begin
        input_clock = 1'b0;
        forever #5 input_clock = ~input_clock;
    end

    always @(negedge input_clock) begin
        if (period_valid === 1'b1) pv_count <= pv_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge input_clock);
        #1;
    endtask

    task automatic drive(input logic v);
        measured_clock = v;
        step();
    endtask

    task automatic run_wave(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < h; i++) drive(1'b1);
            for (int i = 0; i < l; i++) drive(1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_high"}, 32'(high_time), 32'd0);
        check({tag, "_pv"}, 32'(period_valid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        int c0;
        checks = 0;
        errors = 0;
        pv_count = 0;
        reset_n = 1'b0;
        enable = 1'b0;
        measured_clock = 1'b0;

        vecs[0] = '{3, 5, 2, 2, 8, 3, 1'b0};
        vecs[1] = '{3, 5, 1, 1, 8, 3, 1'b1};
        vecs[2] = '{4, 4, 1, 1, 8, 3, 1'b1};
        vecs[3] = '{3, 5, 1, 1, 8, 4, 1'b0};
        vecs[4] = '{3, 5, 4, 4, 8, 3, 1'b1};
        vecs[5] = '{2, 2, 2, 2, 4, 2, 1'b0};
        vecs[6] = '{2, 2, 3, 3, 4, 2, 1'b1};
        vecs[7] = '{1, 3, 2, 2, 4, 1, 1'b0};
        vecs[8] = '{3, 5, 5, 5, 8, 3, 1'b1};

        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();
        check_all_zero("idle");
        enable = 1'b1;
        step();

        // first rise only arms; second rise captures two edges after sampling
        run_wave(3, 5, 1);
        drive(1'b1);
        check("lat_k", 32'(period_valid), 32'd0);
        drive(1'b1);
        check("lat_k1", 32'(period_valid), 32'd0);
        drive(1'b1);
        check("lat_k2_pv", 32'(period_valid), 32'd1);
        check("lat_k2_period", 32'(period), 32'd8);
        check("lat_k2_high", 32'(high_time), 32'd3);
        for (int i = 0; i < 5; i++) drive(1'b0);

        for (int v = 0; v < 9; v++) begin
            c0 = pv_count;
            run_wave(vecs[v].h, vecs[v].l, vecs[v].n);
            check($sformatf("v%0d_caps", v), 32'(pv_count - c0), 32'(vecs[v].exp_caps));
            check($sformatf("v%0d_period", v), 32'(period), 32'(vecs[v].exp_period));
            check($sformatf("v%0d_high", v), 32'(high_time), 32'(vecs[v].exp_high));
            check($sformatf("v%0d_locked", v), 32'(locked), 32'(vecs[v].exp_locked));
            check($sformatf("v%0d_timeout", v), 32'(timeout), 32'd0);
        end

        // stall: timeout exactly 100 cycles after the last rise's counter load
        for (int i = 0; i < 94; i++) drive(1'b0);
        check("to_before", 32'(timeout), 32'd0);
        check("to_before_locked", 32'(locked), 32'd1);
        drive(1'b0);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_period", 32'(period), 32'd0);
        check("to_high", 32'(high_time), 32'd0);
        check("to_locked", 32'(locked), 32'd0);
        c0 = pv_count;
        run_wave(3, 5, 2);
        check("resume_caps", 32'(pv_count - c0), 32'd1);
        check("resume_timeout", 32'(timeout), 32'd0);
        check("resume_period", 32'(period), 32'd8);
        run_wave(3, 5, 4);
        check("relock", 32'(locked), 32'd1);

        // disable mid-high while locked
        drive(1'b1);
        enable = 1'b0;
        drive(1'b1);
        check("dis_locked", 32'(locked), 32'd0);
        check("dis_period", 32'(period), 32'd8);
        check("dis_high", 32'(high_time), 32'd3);
        check("dis_pv", 32'(period_valid), 32'd0);
        c0 = pv_count;
        drive(1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0);
        enable = 1'b1;
        run_wave(3, 5, 1);
        check("reen_first_rise", 32'(pv_count - c0), 32'd0);
        run_wave(3, 5, 1);
        check("reen_second_rise", 32'(pv_count - c0), 32'd1);
        check("reen_period", 32'(period), 32'd8);
        check("reen_locked", 32'(locked), 32'd0);

        // asynchronous reset mid-high phase, away from any clock edge
        drive(1'b1);
        drive(1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        measured_clock = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        c0 = pv_count;
        run_wave(3, 5, 2);
        check("post_rst_caps", 32'(pv_count - c0), 32'd1);
        check("post_rst_period", 32'(period), 32'd8);
        check("post_rst_high", 32'(high_time), 32'd3);
        check("post_rst_locked", 32'(locked), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
